// File: rtl/snd_pkg.sv
// Shared definitions for the mapper expansion-audio output path.
package snd_pkg;

    localparam int SND_LVL_W = 7;
    localparam int SND_PCM_W = 10;

    typedef logic [SND_PCM_W-1:0] snd_pcm_t;

    localparam snd_pcm_t SND_PCM_MAX = 10'd1023;

    // Saturate an 11-bit level product to the PCM range.
    function automatic snd_pcm_t snd_clamp(input logic [SND_PCM_W:0] v);
        return (v > {1'b0, SND_PCM_MAX}) ? SND_PCM_MAX : v[SND_PCM_W-1:0];
    endfunction

endpackage

// File: rtl/snd_sd_mod.sv
// First-order sigma-delta modulator: the carry out of a 10-bit phase
// accumulator is the 1-bit DAC stream, so the ones density equals pcm/1024.
module snd_sd_mod
    import snd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SND_PCM_W-1:0] pcm,
    output logic                 dac_out
);

    logic [SND_PCM_W-1:0] sd_acc_q, sd_acc_d;
    logic                 dac_q, dac_d;
    logic [SND_PCM_W:0]   sum;

    // Accumulate the level; the overflow bit becomes the next output bit.
    always_comb begin
        sum      = {1'b0, sd_acc_q} + {1'b0, pcm};
        sd_acc_d = sum[SND_PCM_W-1:0];
        dac_d    = sum[SND_PCM_W];
    end

    // Accumulator and output bit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sd_acc_q <= '0;
            dac_q    <= 1'b0;
        end else begin
            sd_acc_q <= sd_acc_d;
            dac_q    <= dac_d;
        end
    end

    assign dac_out = dac_q;

endmodule

// File: rtl/snd_exp_dac.sv
// Expansion-audio output stage: synchronises cpu_m2, captures the 7-bit level
// on each M2 rise, scales/clamps/mutes it, optionally low-pass filters it and
// drives a 10-bit PCM level plus a sigma-delta DAC pin.
// Optional one-pole IIR filter: define SND_EXP_LPF_EN.
module snd_exp_dac
    import snd_pkg::*;
#(
    parameter int unsigned GAIN      = 8,
    parameter int unsigned TO_W      = 12,
    parameter int unsigned LPF_SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_m2,
    input  logic [SND_LVL_W-1:0] snd_in,
    input  logic                 mute,
    output logic [SND_PCM_W-1:0] pcm,
    output logic                 sample_stb,
    output logic                 m2_alive,
    output logic                 dac_out
);

    localparam logic [3:0]      GAIN_L = 4'(GAIN);
    localparam logic [TO_W-1:0] TO_MAX = {TO_W{1'b1}};

    logic                 s1_q, s2_q, s3_q;
    logic [1:0]           fill_q, fill_d;
    logic                 armed_q, armed_d;
    logic [TO_W-1:0]      to_ctr_q, to_ctr_d;
    logic                 alive_q, alive_d;
    logic                 v1_q, v1_d;
    logic [SND_LVL_W-1:0] sample_q, sample_d;
    logic                 v2_q, v2_d;
    snd_pcm_t             scaled_q, scaled_d;
    logic                 stb_q, stb_d;
    snd_pcm_t             pcm_q, pcm_d;
    logic                 m2_rise, sat, alive_now, timeout_fire;
    logic [SND_PCM_W:0]   prod;
`ifdef SND_EXP_LPF_EN
    localparam int unsigned ACC_W = SND_PCM_W + LPF_SHIFT;
    logic [ACC_W-1:0]     lpf_acc_q, lpf_acc_d;
`endif

    // Edge detect, timeout, capture, scale and output stage next-state.
    always_comb begin
        fill_d = {fill_q[0], 1'b1};
        // Reset leaves zeros in the synchroniser that are not real M2 samples;
        // only arm edge detection after a genuine low has come through.
        armed_d      = armed_q | (fill_q[1] & ~s2_q);
        m2_rise      = s2_q & ~s3_q & armed_q;
        sat          = (to_ctr_q == TO_MAX);
        alive_now    = alive_q & ~sat;
        timeout_fire = alive_q & sat & ~m2_rise;

        to_ctr_d = to_ctr_q;
        alive_d  = alive_q;
        if (m2_rise) begin
            to_ctr_d = '0;
            alive_d  = 1'b1;
        end else if (sat) begin
            alive_d  = 1'b0;
        end else begin
            to_ctr_d = to_ctr_q + TO_W'(1);
        end

        // A timeout pushes one zero sample through so pcm decays to silence.
        v1_d     = m2_rise | timeout_fire;
        sample_d = sample_q;
        if (v1_d)
            sample_d = (m2_rise & alive_now) ? snd_in : '0;

        prod     = (SND_PCM_W+1)'(sample_q) * (SND_PCM_W+1)'(GAIN_L);
        v2_d     = v1_q;
        scaled_d = scaled_q;
        if (v1_q)
            scaled_d = mute ? '0 : snd_clamp(prod);

        stb_d = v2_q;
        pcm_d = pcm_q;
`ifdef SND_EXP_LPF_EN
        lpf_acc_d = lpf_acc_q;
        if (v2_q) begin
            lpf_acc_d = lpf_acc_q - (lpf_acc_q >> LPF_SHIFT) + ACC_W'(scaled_q);
            pcm_d     = lpf_acc_d[LPF_SHIFT +: SND_PCM_W];
        end
`else
        if (v2_q)
            pcm_d = scaled_q;
`endif
    end

    // State registers; reset discards any sample in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            fill_q   <= '0;
            armed_q  <= 1'b0;
            to_ctr_q <= '0;
            alive_q  <= 1'b0;
            v1_q     <= 1'b0;
            sample_q <= '0;
            v2_q     <= 1'b0;
            scaled_q <= '0;
            stb_q    <= 1'b0;
            pcm_q    <= '0;
`ifdef SND_EXP_LPF_EN
            lpf_acc_q <= '0;
`endif
        end else begin
            s1_q     <= cpu_m2;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            fill_q   <= fill_d;
            armed_q  <= armed_d;
            to_ctr_q <= to_ctr_d;
            alive_q  <= alive_d;
            v1_q     <= v1_d;
            sample_q <= sample_d;
            v2_q     <= v2_d;
            scaled_q <= scaled_d;
            stb_q    <= stb_d;
            pcm_q    <= pcm_d;
`ifdef SND_EXP_LPF_EN
            lpf_acc_q <= lpf_acc_d;
`endif
        end
    end

    snd_sd_mod u_sd (
        .clk     (clk),
        .rst     (rst),
        .pcm     (pcm_q),
        .dac_out (dac_out)
    );

    assign pcm        = pcm_q;
    assign sample_stb = stb_q;
    assign m2_alive   = alive_q;

endmodule

// File: doc/snd_exp_dac.md
# snd_exp_dac

Downstream output stage for the mapper expansion-audio generators. It captures the 7-bit expansion level in the `cpu_m2` domain and moves it into the system `clk` domain. It then applies gain, clamping, mute and an optional low-pass filter, and drives both a 10-bit PCM level and a first-order sigma-delta 1-bit DAC pin. It sits between the per-mapper sound block output and the cartridge audio pin and digital mixer.

## Interface
Parameters:
- `GAIN`, default 8: unsigned 4-bit multiplier applied to the captured sample.
- `TO_W`, default 12: width of the m2-absence timeout counter.
- `LPF_SHIFT`, default 4: IIR filter coefficient exponent (k = 2^-LPF_SHIFT). Used only with `SND_EXP_LPF_EN`.

Ports:
- `clk` in 1: system clock. Must be at least 4× the `cpu_m2` frequency.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_m2` in 1: CPU M2, asynchronous to `clk`.
- `snd_in` in 7: expansion level. It changes only on the falling edge of `cpu_m2`.
- `mute` in 1: synchronous to `clk`. Forces the scaled sample to 0.
- `pcm` out 10: processed level, unsigned.
- `sample_stb` out 1: one-`clk` pulse when `pcm` updates.
- `m2_alive` out 1: high while M2 edges are arriving.
- `dac_out` out 1: sigma-delta bitstream.

## Operation
- **M2 synchroniser:** `cpu_m2` passes through two flops (s1, s2) plus a delay flop s3. A rising edge E is a `clk` cycle where s2 is high and s3 is low. Capture happens on the rising edge, half an M2 period after `snd_in` last changed.
- **Capture (E+1):** `sample` takes `snd_in`. It takes 0 instead if `m2_alive` was low at E.
- **Scale (E+2):** `scaled` = (`mute` ? 0 : `sample` × `GAIN`).
  - The product is 11 bits wide.
  - It clamps to 1023 when above 1023.
- **Filter/output (E+3):** `pcm` is updated and `sample_stb` pulses for 1 cycle.
  - With the filter: see Configuration.
  - Without the filter: `pcm` = `scaled`.
- **Sigma-delta (every `clk`):** {`dac_out`, `sd_acc`[9:0]} ← `sd_acc` + `pcm`.
  - The ones-density over 1024 cycles equals `pcm`/1024 exactly, for a constant `pcm`.
- **Timeout:**
  - `to_ctr` clears to 0 at E.
  - Otherwise `to_ctr` increments each `clk`, saturating at 2^TO_W−1.
  - At saturation `m2_alive` goes low. `scaled` is forced to 0 and a strobe is generated once, so `pcm` moves toward 0.
  - `m2_alive` returns high at E+1 after the next edge.
- **Simultaneous events:**
  - Edge at the same cycle as saturation: the edge wins. The counter clears and the sample is captured as 0 (alive was low at E).
  - `mute` is sampled at E+2 only.
- **Reset:** `rst` high on any `clk` edge returns the following to 0, discarding any in-flight pipeline stage:
  - `pcm`, `sample_stb`, `m2_alive`, `dac_out`, `sd_acc`, `sample`, `scaled`, `to_ctr`, the filter accumulator, and the synchroniser flops.

## Timing
- Latency from the M2 rising edge at the pin to `pcm` update is 2 sync cycles + 3 pipeline cycles (edge detect at E, `pcm` at E+3).
- `dac_out` first reflects a new `pcm` at E+4.
- Edges closer than 4 `clk` apart are not supported.
- The pipeline carries one sample at a time. There is no backpressure: `sample_stb` is informational only.

## Configuration
- **`SND_EXP_LPF_EN` defined:**
  - A one-pole IIR is inserted between scale and output.
  - The accumulator `lpf_acc` is (10+`LPF_SHIFT`) bits.
  - On each strobe: `lpf_acc` ← `lpf_acc` − (`lpf_acc` >> `LPF_SHIFT`) + `scaled`.
  - `pcm` = `lpf_acc` >> `LPF_SHIFT` (truncating).
  - Steady state: `pcm` = `scaled`.
  - The accumulator cannot overflow: its maximum is 1023 × 2^LPF_SHIFT.
- **Undefined:** `pcm` = `scaled`, and no filter registers exist.

## Structure
- **Shared package `snd_pkg`:**
  - `SND_LVL_W` = 7 (expansion level width).
  - `SND_PCM_W` = 10.
  - `SND_PCM_MAX` = 1023.
  - `typedef logic [9:0] snd_pcm_t`.
- **Sub-module `snd_sd_mod`:** the first-order sigma-delta modulator.
  - Ports: `clk`, `rst`, `pcm` in, `dac_out` out.
  - Reusable by other mapper audio outputs.
- The synchroniser, timeout, scale and filter stay in the top module.

## Test plan
- `GAIN`=8, M2 at 1/28 of `clk`, `snd_in`=61:
  - `pcm`=488 at E+3 with `sample_stb` high for 1 cycle.
  - Count `dac_out` ones over 1024 `clk` → exactly 488.
- `GAIN`=15, `snd_in`=127 → `pcm`=1023 (clamp).
  - Then `snd_in`=0 → `pcm`=0.
  - Exactly 1023 ones per 1024 cycles while at 1023.
- `snd_in`=40, `GAIN`=8, `mute` raised:
  - Next strobe gives `pcm`=0.
  - Releasing `mute` gives `pcm`=320 on the following strobe.
- Stop M2 with `TO_W`=6, `pcm`=320:
  - 63 cycles after the last edge `m2_alive`=0 and `pcm`→0.
  - Restart M2: `m2_alive`=1 at E+1 and the first captured sample = 0. The next sample is 320.
- `SND_EXP_LPF_EN`, `LPF_SHIFT`=4, step 0→488:
  - First strobe `pcm`=30.
  - Converges to 488.
  - Never exceeds 488.
- Assert `rst` for 1 cycle mid-pipeline (at E+1): all outputs 0 next cycle, no `sample_stb` for that edge. The next edge proceeds normally.
